proc_run_checker: RTL

- Synthesizable, parametrised run-and-check harness for the single-cycle processor.
- Sequences up to NUM_PROGS programs back to back. For each program it resets the processor to that program's start PC and waits until currentPC reaches the program's end PC.
- After SETTLE_CYCLES more cycles it compares dMemOut with the expected pass code. A per-program watchdog bounds every run.
- Sits beside SingleCycleProc in bench and FPGA top levels, and replaces hand-written while-loop and pass-task sequencing.

---
 rtl/proc_run_checker_if.sv | 37 +++
 rtl/proc_run_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_checker_if.sv
// Bundle of sequencing controls, processor observation inputs and result outputs
// shared between proc_run_checker (slave) and whatever drives/observes it (master).
interface proc_run_checker_if #(
    parameter int PC_W      = 64,
    parameter int DATA_W    = 64,
    parameter int NUM_PROGS = 4
);
    logic                        start;
    logic [3:0]                  numProgs;
    logic [NUM_PROGS*PC_W-1:0]   startPCs;
    logic [NUM_PROGS*PC_W-1:0]   endPCs;
    logic [NUM_PROGS*DATA_W-1:0] expected;
    logic [PC_W-1:0]             currentPC;
    logic [DATA_W-1:0]           dMemOut;

    logic                        procReset;
    logic [PC_W-1:0]             startPC;
    logic [3:0]                  progIdx;
    logic                        busy;
    logic                        done;
    logic [4:0]                  passCount;
    logic [NUM_PROGS-1:0]        failMask;
    logic [NUM_PROGS-1:0]        timeoutMask;
    logic                        allPassed;

    modport master (
        output start, numProgs, startPCs, endPCs, expected, currentPC, dMemOut,
        input  procReset, startPC, progIdx, busy, done, passCount,
               failMask, timeoutMask, allPassed
    );

    modport slave (
        input  start, numProgs, startPCs, endPCs, expected, currentPC, dMemOut,
        output procReset, startPC, progIdx, busy, done, passCount,
               failMask, timeoutMask, allPassed
    );
endinterface

// File: rtl/proc_run_checker.sv
// Run-and-check harness: resets the processor to each program's start PC, waits for
// its end PC (bounded by a watchdog), then compares dMemOut with the pass code.
module proc_run_checker #(
    parameter int PC_W          = 64,
    parameter int DATA_W        = 64,
    parameter int NUM_PROGS     = 4,
    parameter int WDOG_W        = 16,
    parameter int RESET_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    proc_run_checker_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRST   = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int                   PH_W        = 16;
    localparam logic [PH_W-1:0]      RST_LAST    = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0]      SETTLE_LAST = PH_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [4:0]           MAX_PROGS   = 5'(NUM_PROGS);
    localparam logic [NUM_PROGS-1:0] SLOT0       = NUM_PROGS'(1);
    localparam logic [WDOG_W-1:0]    WDOG_ONES   = {WDOG_W{1'b1}};

    function automatic logic [PC_W-1:0] pc_slot(input logic [NUM_PROGS*PC_W-1:0] v,
                                                input logic [3:0]                idx);
        logic [PC_W-1:0] r;
        r = {PC_W{1'b0}};
        for (int k = 0; k < NUM_PROGS; k++) begin
            if (idx == 4'(k)) begin
                r = v[k*PC_W +: PC_W];
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] data_slot(input logic [NUM_PROGS*DATA_W-1:0] v,
                                                    input logic [3:0]                  idx);
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_PROGS; k++) begin
            if (idx == 4'(k)) begin
                r = v[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [4:0]            eff_cnt_q, eff_cnt_d;
    logic [3:0]            prog_idx_q, prog_idx_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  proc_reset_q, proc_reset_d;
    logic [PC_W-1:0]       start_pc_q, start_pc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4:0]            pass_count_q, pass_count_d;
    logic [NUM_PROGS-1:0]  fail_mask_q, fail_mask_d;
    logic [NUM_PROGS-1:0]  timeout_mask_q, timeout_mask_d;
    logic                  all_passed_q, all_passed_d;

    logic [PC_W-1:0]       end_pc_s;
    logic [DATA_W-1:0]     exp_code_s;
    logic                  end_hit_s;
    logic                  wdog_exp_s;
    logic                  more_s;
    logic [4:0]            req_cnt_s;
    logic [NUM_PROGS-1:0]  slot_bit_s;

    assign end_pc_s   = pc_slot(bus.endPCs, prog_idx_q);
    assign exp_code_s = data_slot(bus.expected, prog_idx_q);
    assign end_hit_s  = (bus.currentPC >= end_pc_s);
    // Compare the post-increment value so expiry lands on exactly 2^WDOG_W-1 RUN cycles.
    assign wdog_exp_s = ((wdog_q + WDOG_W'(1)) == WDOG_ONES);
    assign more_s     = (({1'b0, prog_idx_q} + 5'd1) < eff_cnt_q);
    assign req_cnt_s  = ((bus.numProgs == 4'd0) || ({1'b0, bus.numProgs} > MAX_PROGS))
                        ? MAX_PROGS : {1'b0, bus.numProgs};
    assign slot_bit_s = SLOT0 << prog_idx_q;

    // State and result registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            eff_cnt_q      <= 5'd0;
            prog_idx_q     <= 4'd0;
            phase_q        <= {PH_W{1'b0}};
            wdog_q         <= {WDOG_W{1'b0}};
            proc_reset_q   <= 1'b1;
            start_pc_q     <= {PC_W{1'b0}};
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_count_q   <= 5'd0;
            fail_mask_q    <= {NUM_PROGS{1'b0}};
            timeout_mask_q <= {NUM_PROGS{1'b0}};
            all_passed_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            eff_cnt_q      <= eff_cnt_d;
            prog_idx_q     <= prog_idx_d;
            phase_q        <= phase_d;
            wdog_q         <= wdog_d;
            proc_reset_q   <= proc_reset_d;
            start_pc_q     <= start_pc_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_count_q   <= pass_count_d;
            fail_mask_q    <= fail_mask_d;
            timeout_mask_q <= timeout_mask_d;
            all_passed_q   <= all_passed_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_PRST;
                else           state_d = S_IDLE;
            end
            S_PRST: begin
                if (phase_q == RST_LAST) state_d = S_RUN;
                else                     state_d = S_PRST;
            end
            S_RUN: begin
                if (end_hit_s) begin
                    if (SETTLE_CYCLES == 0) state_d = S_CHECK;
                    else                    state_d = S_SETTLE;
                end else if (wdog_exp_s) begin
                    if (more_s) state_d = S_PRST;
                    else        state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_SETTLE: begin
                if (phase_q == SETTLE_LAST) state_d = S_CHECK;
                else                        state_d = S_SETTLE;
            end
            S_CHECK: begin
                if (more_s) state_d = S_PRST;
                else        state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.start) state_d = S_PRST;
                else           state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath, counters and registered output values derived from the transition.
    always_comb begin
        eff_cnt_d      = eff_cnt_q;
        prog_idx_d     = prog_idx_q;
        pass_count_d   = pass_count_q;
        fail_mask_d    = fail_mask_q;
        timeout_mask_d = timeout_mask_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_d == S_PRST) begin
                    eff_cnt_d      = req_cnt_s;
                    prog_idx_d     = 4'd0;
                    pass_count_d   = 5'd0;
                    fail_mask_d    = {NUM_PROGS{1'b0}};
                    timeout_mask_d = {NUM_PROGS{1'b0}};
                end else begin
                    eff_cnt_d = eff_cnt_q;
                end
            end
            S_RUN: begin
                if (!end_hit_s && wdog_exp_s) begin
                    fail_mask_d    = fail_mask_q | slot_bit_s;
                    timeout_mask_d = timeout_mask_q | slot_bit_s;
                    if (more_s) prog_idx_d = prog_idx_q + 4'd1;
                    else        prog_idx_d = prog_idx_q;
                end else begin
                    prog_idx_d = prog_idx_q;
                end
            end
            S_CHECK: begin
                if (bus.dMemOut == exp_code_s) pass_count_d = pass_count_q + 5'd1;
                else                           fail_mask_d  = fail_mask_q | slot_bit_s;
                if (more_s) prog_idx_d = prog_idx_q + 4'd1;
                else        prog_idx_d = prog_idx_q;
            end
            default: begin
                prog_idx_d = prog_idx_q;
            end
        endcase

        if (state_d != state_q) phase_d = {PH_W{1'b0}};
        else                    phase_d = phase_q + PH_W'(1);

        if (state_d == S_PRST)                               wdog_d = {WDOG_W{1'b0}};
        else if ((state_q == S_RUN) || (state_q == S_SETTLE)) wdog_d = wdog_q + WDOG_W'(1);
        else                                                  wdog_d = wdog_q;

        if (state_d == S_PRST) start_pc_d = pc_slot(bus.startPCs, prog_idx_d);
        else                   start_pc_d = start_pc_q;

        proc_reset_d = (state_d == S_IDLE) || (state_d == S_PRST) || (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
        all_passed_d = (state_d == S_DONE) && (pass_count_d == eff_cnt_d);
    end

    assign bus.procReset   = proc_reset_q;
    assign bus.startPC     = start_pc_q;
    assign bus.progIdx     = prog_idx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.passCount   = pass_count_q;
    assign bus.failMask    = fail_mask_q;
    assign bus.timeoutMask = timeout_mask_q;
    assign bus.allPassed   = all_passed_q;

endmodule
